// File: rtl/sdram_dma_fetch_pkg.sv
// sdram_dma_pkg: shared types and constants for the SDRAM prefetch DMA.
// The fetch FSM states, wishbone cycle-type and byte-select encodings, and
// a helper that maps a request kind to its word count live here.
package sdram_dma_pkg;

  // Fetch engine states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    REQ   = 3'd2,
    BEAT2 = 3'd3,
    GAP   = 3'd4
  } dma_state_e;

  // Wishbone cycle type identifiers and byte lane select
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [3:0] SEL_ALL     = 4'b1111;

  // Word pointer width (byte address bits [23:2])
  localparam int WORD_AW = 22;

  // Number of words moved by one request: two for a burst, one otherwise
  function automatic logic [1:0] words_of(input logic burst);
    if (burst) begin
      return 2'd2;
    end else begin
      return 2'd1;
    end
  endfunction

endpackage

// File: rtl/sdram_dma_fetch_fifo.sv
// dma_fifo: synchronous FIFO, DEPTH x 32 bits, used as the prefetch buffer.
// Flush takes priority over push and pop in the same cycle. A pop while
// empty and a push while full are ignored. The head word is presented
// combinationally on pop_data.
module dma_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [31:0]   pop_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  logic          do_push_s;
  logic          do_pop_s;
  logic          full_s;
  logic          empty_s;

  // Qualify push/pop against the current occupancy
  always_comb begin
    full_s    = (level_r == DEPTH_L);
    empty_s   = (level_r == {(AW+1){1'b0}});
    do_push_s = push && !full_s;
    do_pop_s  = pop && !empty_s;
  end

  // Storage write port; contents need no reset since level gates visibility
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign empty    = empty_s;
  assign full     = full_s;
  assign level    = level_r;

endmodule

// File: rtl/sdram_dma_fetch.sv
// sdram_dma_fetch: wishbone read master that prefetches a linear SDRAM
// region into a local FIFO for video/sound consumers. Issues 2-word
// incrementing bursts when the word pointer is even and enough words and
// FIFO credit remain, otherwise single classic reads.
// Optional macro DMA_CIRCULAR_EN: when defined, reaching the end pointer
// reloads the latched base and fetching continues until dma_abort.
module sdram_dma_fetch
  import sdram_dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               dma_start,
  input  logic               dma_abort,
  input  logic [23:0]        dma_base,
  input  logic [23:0]        dma_end,
  output logic               dma_busy,
  output logic               dma_done,
  input  logic               pop,
  output logic [31:0]        pop_data,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic [23:0]        wb_adr,
  output logic [3:0]         wb_sel,
  output logic [2:0]         wb_cti,
  output logic               wb_stb,
  output logic               wb_cyc,
  output logic               wb_we,
  input  logic [31:0]        wb_dat_i,
  input  logic               wb_ack
);

  localparam logic [FIFO_AW+1:0] DEPTH_C = (FIFO_AW+2)'(FIFO_DEPTH);
  localparam logic [FIFO_AW+1:0] CRED_1  = (FIFO_AW+2)'(1);
  localparam logic [FIFO_AW+1:0] CRED_2  = (FIFO_AW+2)'(2);

  dma_state_e         state_r;
  logic [WORD_AW-1:0] ptr_r;
  logic [WORD_AW-1:0] end_r;
  logic               burst_r;
  logic               abort_pend_r;
  logic               busy_r;
  logic               done_r;
  logic               wb_stb_r;
  logic               wb_cyc_r;
  logic [23:0]        wb_adr_r;
  logic [2:0]         wb_cti_r;
`ifdef DMA_CIRCULAR_EN
  logic [WORD_AW-1:0] base_r;
`endif

  logic [WORD_AW-1:0] remaining_s;
  logic [1:0]         inflight_s;
  logic [FIFO_AW+1:0] credit_s;
  logic               can_burst_s;
  logic               can_single_s;
  logic               beat_ack_s;
  logic               final_ack_s;
  logic               aborting_s;
  logic               start_ok_s;
  logic               push_s;
  logic               flush_s;
  logic               fifo_full_s;
  logic               unused_s;

  // Low address bits are don't-care: every access is word aligned
  assign unused_s = ^{dma_base[1:0], dma_end[1:0]};

  // Credit, request choice and FIFO control derived from current state
  always_comb begin
    remaining_s = end_r - ptr_r;
    case (state_r)
      REQ:     inflight_s = burst_r ? 2'd2 : 2'd1;
      BEAT2:   inflight_s = 2'd1;
      default: inflight_s = 2'd0;
    endcase
    credit_s     = DEPTH_C - {1'b0, level} - {{FIFO_AW{1'b0}}, inflight_s};
    can_burst_s  = !ptr_r[0] && (remaining_s >= 22'd2) && (credit_s >= CRED_2);
    can_single_s = (credit_s >= CRED_1);
    beat_ack_s   = wb_ack && ((state_r == REQ) || (state_r == BEAT2));
    final_ack_s  = wb_ack && (((state_r == REQ) && !burst_r) || (state_r == BEAT2));
    aborting_s   = abort_pend_r || dma_abort;
    start_ok_s   = (state_r == IDLE) && dma_start && !dma_abort;
    push_s       = beat_ack_s && !aborting_s && !fifo_full_s;
    flush_s      = dma_abort || start_ok_s || (final_ack_s && aborting_s);
  end

  // Fetch FSM with registered bus and status outputs
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_r      <= IDLE;
      ptr_r        <= {WORD_AW{1'b0}};
      end_r        <= {WORD_AW{1'b0}};
      burst_r      <= 1'b0;
      abort_pend_r <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      wb_stb_r     <= 1'b0;
      wb_cyc_r     <= 1'b0;
      wb_adr_r     <= 24'h000000;
      wb_cti_r     <= CTI_CLASSIC;
`ifdef DMA_CIRCULAR_EN
      base_r       <= {WORD_AW{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (dma_abort) begin
            done_r <= 1'b0;
          end else if (dma_start) begin
            ptr_r <= dma_base[23:2];
            end_r <= dma_end[23:2];
`ifdef DMA_CIRCULAR_EN
            base_r <= dma_base[23:2];
`endif
            if (dma_base[23:2] == dma_end[23:2]) begin
`ifdef DMA_CIRCULAR_EN
              done_r <= 1'b0;
`else
              done_r <= 1'b1;
`endif
            end else begin
              done_r  <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= ARB;
            end
          end else begin
            state_r <= IDLE;
          end
        end

        ARB: begin
          if (dma_abort) begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (ptr_r == end_r) begin
`ifdef DMA_CIRCULAR_EN
            ptr_r   <= base_r;
`else
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
`endif
          end else if (can_burst_s) begin
            wb_stb_r <= 1'b1;
            wb_cyc_r <= 1'b1;
            wb_adr_r <= {ptr_r, 2'b00};
            wb_cti_r <= CTI_INCR;
            burst_r  <= 1'b1;
            state_r  <= REQ;
          end else if (can_single_s) begin
            wb_stb_r <= 1'b1;
            wb_cyc_r <= 1'b1;
            wb_adr_r <= {ptr_r, 2'b00};
            wb_cti_r <= CTI_CLASSIC;
            burst_r  <= 1'b0;
            state_r  <= REQ;
          end else begin
            state_r <= ARB;
          end
        end

        REQ, BEAT2: begin
          // An abort cannot cut a bus cycle short; remember it until the end
          if (dma_abort) begin
            abort_pend_r <= 1'b1;
          end
          if (final_ack_s) begin
            wb_stb_r     <= 1'b0;
            wb_cyc_r     <= 1'b0;
            abort_pend_r <= 1'b0;
            if (aborting_s) begin
              done_r  <= 1'b0;
              busy_r  <= 1'b0;
              state_r <= IDLE;
            end else begin
              ptr_r   <= ptr_r + {{(WORD_AW-2){1'b0}}, words_of(burst_r)};
              state_r <= GAP;
            end
          end else if (wb_ack) begin
            state_r <= BEAT2;
          end else begin
            state_r <= state_r;
          end
        end

        GAP: begin
          if (dma_abort) begin
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= ARB;
          end
        end

        default: begin
          wb_stb_r <= 1'b0;
          wb_cyc_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  dma_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .push      (push_s),
    .push_data (wb_dat_i),
    .pop       (pop),
    .flush     (flush_s),
    .pop_data  (pop_data),
    .empty     (empty),
    .full      (fifo_full_s),
    .level     (level)
  );

  assign dma_busy = busy_r;
  assign dma_done = done_r;
  assign wb_stb   = wb_stb_r;
  assign wb_cyc   = wb_cyc_r;
  assign wb_adr   = wb_adr_r;
  assign wb_cti   = wb_cti_r;
  assign wb_sel   = SEL_ALL;
  assign wb_we    = 1'b0;

endmodule
